// File: rtl/conv_y_collector_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | conv_y_collector_if : y-stream handshake and host read/release bus      |
// | Rev 1.0 - initial release (checksum signal present with Y_CHECKSUM_EN)  |
// +-------------------------------------------------------------------------+
interface conv_y_collector_if #(
  parameter int WIDTH = 12,
  parameter int ADDRY = 3,
  parameter int CNTW  = 8
);
  logic signed [WIDTH-1:0] s_data_in_y;
  logic                    s_valid_y;
  logic                    s_ready_y;
  logic                    rd_en;
  logic [ADDRY-1:0]        rd_addr;
  logic [WIDTH-1:0]        rd_data;
  logic                    rd_valid;
  logic                    frame_ready;
  logic                    frame_release;
  logic [CNTW-1:0]         frame_count;
`ifdef Y_CHECKSUM_EN
  logic [WIDTH-1:0]        checksum;

  modport master (
    output s_data_in_y, s_valid_y, rd_en, rd_addr, frame_release,
    input  s_ready_y, rd_data, rd_valid, frame_ready, frame_count, checksum
  );
  modport slave (
    input  s_data_in_y, s_valid_y, rd_en, rd_addr, frame_release,
    output s_ready_y, rd_data, rd_valid, frame_ready, frame_count, checksum
  );
`else
  modport master (
    output s_data_in_y, s_valid_y, rd_en, rd_addr, frame_release,
    input  s_ready_y, rd_data, rd_valid, frame_ready, frame_count
  );
  modport slave (
    input  s_data_in_y, s_valid_y, rd_en, rd_addr, frame_release,
    output s_ready_y, rd_data, rd_valid, frame_ready, frame_count
  );
`endif
endinterface
`default_nettype wire

// File: rtl/conv_y_collector.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | conv_y_collector : buffers one conv-layer y frame, stalls until release |
// | Optional running frame checksum with Y_CHECKSUM_EN.  Rev 1.0            |
// +-------------------------------------------------------------------------+
module conv_y_collector #(
  parameter int WIDTH = 12,
  parameter int LENY  = 5,
  parameter int ADDRY = 3,
  parameter int CNTW  = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  conv_y_collector_if.slave bus
);

  localparam logic [0:0]       c_FILL = 1'b0;
  localparam logic [0:0]       c_FULL = 1'b1;
  localparam logic [ADDRY-1:0] c_LAST = ADDRY'(LENY - 1);

  logic [0:0]       r_state;
  logic [ADDRY-1:0] r_wr_ptr;
  logic [CNTW-1:0]  r_frame_count;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic [WIDTH-1:0] r_mem [LENY];

  logic w_ready;
  logic w_accept;
  logic w_last;

  // Ready depends on state and reset only, never on valid or release.
  assign w_ready  = reset & (r_state == c_FILL);
  assign w_accept = bus.s_valid_y & w_ready;
  assign w_last   = (r_wr_ptr == c_LAST);

  assign bus.s_ready_y   = w_ready;
  assign bus.frame_ready = (r_state == c_FULL);
  assign bus.frame_count = r_frame_count;
  assign bus.rd_data     = r_rd_data;
  assign bus.rd_valid    = r_rd_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= c_FILL;
      r_wr_ptr      <= '0;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        c_FILL: begin
          if (w_accept) begin
            if (w_last) begin
              r_wr_ptr      <= '0;
              r_state       <= c_FULL;
              r_frame_count <= r_frame_count + 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        c_FULL: begin
          if (bus.frame_release) begin
            r_state <= c_FILL;
          end
        end
        default: r_state <= c_FILL;
      endcase
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= bus.s_data_in_y;
    end
  end

  // Registered read sees the pre-edge contents, giving read-before-write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rd_data <= (bus.rd_addr <= c_LAST) ? r_mem[bus.rd_addr] : '0;
      end
    end
  end

`ifdef Y_CHECKSUM_EN
  logic [WIDTH-1:0] r_checksum;

  assign bus.checksum = r_checksum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + bus.s_data_in_y;
    end else if ((r_state == c_FULL) && bus.frame_release) begin
      r_checksum <= '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_conv_y_collector.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_conv_y_collector : directed self-checking bench with frame model     |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_conv_y_collector;

  localparam int c_LENY = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  conv_y_collector_if #(.WIDTH(12), .ADDRY(3), .CNTW(8)) bus ();

  conv_y_collector #(.WIDTH(12), .LENY(c_LENY), .ADDRY(3), .CNTW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: count of samples in the frame, stored samples, frame full flag.
  logic [11:0] m_mem [0:7];
  int          m_len      = 0;
  bit          m_full     = 1'b0;
  int          m_count    = 0;
  bit          m_rd_valid = 1'b0;
  logic [11:0] m_rd_data  = 12'd0;
  logic [11:0] m_sum      = 12'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_len = 0; m_full = 1'b0; m_count = 0;
      m_rd_valid = 1'b0; m_rd_data = 12'd0; m_sum = 12'd0;
    end else begin
      if (bus.rd_en) begin
        m_rd_valid = 1'b1;
        m_rd_data  = (int'(bus.rd_addr) < c_LENY) ? m_mem[bus.rd_addr] : 12'd0;
      end else begin
        m_rd_valid = 1'b0;
      end
      if (!m_full && bus.s_valid_y) begin
        m_mem[m_len] = bus.s_data_in_y;
        m_sum = m_sum + bus.s_data_in_y;
        m_len++;
        if (m_len == c_LENY) begin
          m_full  = 1'b1;
          m_len   = 0;
          m_count = (m_count + 1) % 256;
        end
      end else if (m_full && bus.frame_release) begin
        m_full = 1'b0;
        m_sum  = 12'd0;
      end
    end
  end

  always @(negedge clk) begin
    check("s_ready_y",   32'(bus.s_ready_y),   32'(reset && !m_full));
    check("frame_ready", 32'(bus.frame_ready), 32'(m_full));
    check("frame_count", 32'(bus.frame_count), 32'(m_count));
    check("rd_valid",    32'(bus.rd_valid),    32'(m_rd_valid));
    check("rd_data",     32'(bus.rd_data),     32'(m_rd_data));
`ifdef Y_CHECKSUM_EN
    if (m_full) check("checksum", 32'(bus.checksum), 32'(m_sum));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [11:0] d);
    bit acc;
    bus.s_valid_y   = 1'b1;
    bus.s_data_in_y = d;
    for (int i = 0; i < 20; i++) begin
      acc = bus.s_ready_y;
      tick();
      if (acc) return;
    end
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    bus.s_valid_y = 1'b0;
    tick();
  endtask

  task automatic rd(input logic [2:0] a, input logic [11:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    tick();
    bus.rd_en   = 1'b0;
    check("lit_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("lit_rd_data",  32'(bus.rd_data),  32'(exp));
  endtask

  task automatic pulse_release();
    bus.frame_release = 1'b1;
    tick();
    bus.frame_release = 1'b0;
  endtask

  initial begin
    int t0;
    logic [11:0] vals [5];
    bus.s_valid_y = 1'b0; bus.s_data_in_y = '0; bus.rd_en = 1'b0;
    bus.rd_addr = '0; bus.frame_release = 1'b0;
    repeat (2) tick();
    check("rst_ready",  32'(bus.s_ready_y),   32'd0);
    check("rst_rdata",  32'(bus.rd_data),     32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", 32'(bus.s_ready_y),   32'd1);
    check("post_rst_count", 32'(bus.frame_count), 32'd0);

    // Back-to-back fill
    t0 = cyc;
    for (int i = 1; i <= 5; i++) send(12'(i));
    bus.s_valid_y = 1'b0;
    check("b2b_cycles", 32'(cyc - t0), 32'd5);
    check("b2b_ready",  32'(bus.s_ready_y),   32'd0);
    check("b2b_fready", 32'(bus.frame_ready), 32'd1);
    check("b2b_count",  32'(bus.frame_count), 32'd1);
`ifdef Y_CHECKSUM_EN
    check("b2b_sum", 32'(bus.checksum), 32'd15);
`endif
    for (int i = 0; i < 5; i++) rd(3'(i), 12'(i + 1));
    pulse_release();

    // Gapped valid
    for (int i = 1; i <= 5; i++) begin
      send(12'(10 * i));
      if (i < 5) check("gap_fready", 32'(bus.frame_ready), 32'd0);
      idle();
    end
    check("gap_fready_end", 32'(bus.frame_ready), 32'd1);
    for (int i = 0; i < 5; i++) rd(3'(i), 12'(10 * (i + 1)));

    // Backpressure then release
    bus.s_valid_y = 1'b1; bus.s_data_in_y = 12'd77;
    repeat (3) tick();
    check("bp_ready",  32'(bus.s_ready_y), 32'd0);
    pulse_release();
    check("rel_ready",  32'(bus.s_ready_y),   32'd1);
    check("rel_fready", 32'(bus.frame_ready), 32'd0);
    send(12'd77);
    check("rel_count", 32'(bus.frame_count), 32'd2);
    for (int i = 1; i <= 4; i++) send(12'(i));
    bus.s_valid_y = 1'b0;
    check("bp_count", 32'(bus.frame_count), 32'd3);
    rd(3'd0, 12'd77);
    pulse_release();

    // Signed extremes and out-of-range reads
    vals = '{12'h800, 12'h7FF, 12'hFFF, 12'h000, 12'h001};
    for (int i = 0; i < 5; i++) send(vals[i]);
    bus.s_valid_y = 1'b0;
    for (int i = 0; i < 5; i++) rd(3'(i), vals[i]);
    rd(3'd6, 12'd0);
    rd(3'd7, 12'd0);
    pulse_release();

    // Same-address read during write returns the old word
    bus.rd_en = 1'b1; bus.rd_addr = 3'd0;
    send(12'd99);
    bus.rd_en = 1'b0;
    check("rbw_data", 32'(bus.rd_data), 32'h800);
    send(12'd5); send(12'd6);
    bus.s_valid_y = 1'b0;

    // Asynchronous reset mid-frame
    #3 reset = 1'b0;
    #1;
    check("arst_ready",  32'(bus.s_ready_y),   32'd0);
    check("arst_fready", 32'(bus.frame_ready), 32'd0);
    check("arst_count",  32'(bus.frame_count), 32'd0);
    check("arst_rvalid", 32'(bus.rd_valid),    32'd0);
    check("arst_rdata",  32'(bus.rd_data),     32'd0);
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send(12'(200 + i));
    bus.s_valid_y = 1'b0;
    check("arst_refill_count", 32'(bus.frame_count), 32'd1);
    for (int i = 0; i < 5; i++) rd(3'(i), 12'(200 + i));
    pulse_release();

    // Checksum frames (reads always checked)
    for (int i = 1; i <= 5; i++) send(12'(100 * i));
    bus.s_valid_y = 1'b0;
`ifdef Y_CHECKSUM_EN
    check("cks_1500", 32'(bus.checksum), 32'd1500);
`endif
    rd(3'd4, 12'd500);
    pulse_release();
`ifdef Y_CHECKSUM_EN
    check("cks_clear", 32'(bus.checksum), 32'd0);
`endif
    vals = '{12'h7FF, 12'h001, 12'h000, 12'h000, 12'h000};
    for (int i = 0; i < 5; i++) send(vals[i]);
    bus.s_valid_y = 1'b0;
`ifdef Y_CHECKSUM_EN
    check("cks_wrap", 32'(bus.checksum), 32'h800);
`endif
    rd(3'd1, 12'h001);
    check("final_count", 32'(bus.frame_count), 32'd3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
